// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the SPI memory front end: access sizes, FSM states, grant owner.
// Pure declarations; no latency and no backpressure.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] NBYTES_1 = 3'd1;
  localparam logic [2:0] NBYTES_2 = 3'd2;
  localparam logic [2:0] NBYTES_4 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_t;

  // Size code 3 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SIZE_BYTE || size == SIZE_HALF) ? size : SIZE_WORD;
  endfunction

  function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
    case (norm_size(size))
      SIZE_BYTE: return NBYTES_1;
      SIZE_HALF: return NBYTES_2;
      default:   return NBYTES_4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (norm_size(size))
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// Extracts an N-byte read from the top bytes of the SPI read word and zero/sign-extends it.
// Purely combinational; no backpressure.
module mem_load_format
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic sign_bit;

  assign sign_bit = ~is_unsigned & raw[31];

  always_comb begin
    data = raw;
    case (size)
      SIZE_BYTE: data = {{24{sign_bit}}, raw[31:24]};
      SIZE_HALF: data = {{16{sign_bit}}, raw[31:16]};
      default:   data = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for the SPI memory block; start one edge after grant, done one cycle after mem_done.
// Requesters hold until their done pulse; optional alignment trap via MEM_ARBITER_ALIGN_CHECK_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_write,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        ls_err,
  output logic        mem_start,
  output logic [2:0]  mem_num_bytes,
  output logic [31:0] mem_addr,
  output logic        mem_is_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  state_t      state_q, state_d;
  owner_t      owner_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] fmt_data;
  logic        ls_bad;

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  logic err_q;

  assign ls_bad = ls_req && misaligned(ls_size, ls_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_q == IDLE) && ls_bad;
  end

  assign ls_err = err_q;
`else
  assign ls_bad = 1'b0;
  assign ls_err = 1'b0;
`endif

  mem_load_format u_fmt (
    .raw         (mem_rdata),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (fmt_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ls_req)      state_d = ls_bad ? DONE : BUSY;
        else if (if_req) state_d = BUSY;
      end
      BUSY:    if (mem_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Done pulses are set on entry to DONE and cleared by default, so they last one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q       <= OWNER_IF;
      size_q        <= SIZE_WORD;
      unsigned_q    <= 1'b0;
      mem_start     <= 1'b0;
      mem_num_bytes <= 3'd0;
      mem_addr      <= 32'd0;
      mem_is_write  <= 1'b0;
      mem_wdata     <= 32'd0;
      if_rdata      <= 32'd0;
      ls_rdata      <= 32'd0;
      if_done       <= 1'b0;
      ls_done       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ls_req && ls_bad) begin
            owner_q <= OWNER_LS;
            ls_done <= 1'b1;
          end else if (ls_req) begin
            owner_q       <= OWNER_LS;
            size_q        <= norm_size(ls_size);
            unsigned_q    <= ls_unsigned;
            mem_start     <= 1'b1;
            mem_num_bytes <= size_to_nbytes(ls_size);
            mem_addr      <= ls_addr;
            mem_is_write  <= ls_write;
            mem_wdata     <= ls_wdata;
          end else if (if_req) begin
            owner_q       <= OWNER_IF;
            size_q        <= SIZE_WORD;
            unsigned_q    <= 1'b0;
            mem_start     <= 1'b1;
            mem_num_bytes <= NBYTES_4;
            mem_addr      <= if_addr;
            mem_is_write  <= 1'b0;
            mem_wdata     <= 32'd0;
          end
        end
        BUSY: begin
          if (mem_done) begin
            mem_start <= 1'b0;
            if (owner_q == OWNER_LS) begin
              ls_done <= 1'b1;
              if (!mem_is_write) ls_rdata <= fmt_data;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= fmt_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, a behavioural SPI memory and a decoupled monitor.
// Build with MEM_ARBITER_ALIGN_CHECK_EN to include the misaligned-access case.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_write, ls_unsigned;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, ls_done, ls_err, mem_start, mem_is_write, mem_done;
  logic [2:0]  mem_num_bytes;

  typedef struct {
    bit          is_ls;
    bit          issue;
    logic [2:0]  nb;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
  } resp_t;

  exp_t  sb[$];
  resp_t mq[$];
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_write(ls_write), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .ls_err(ls_err), .mem_start(mem_start), .mem_num_bytes(mem_num_bytes),
    .mem_addr(mem_addr), .mem_is_write(mem_is_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // SPI memory model: answers each start after lat cycles with a one-cycle done.
  initial begin
    resp_t r;
    mem_done  = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_start && mq.size() > 0) begin
        r = mq.pop_front();
        repeat (r.lat) @(negedge clk);
        mem_rdata = r.data;
        mem_done  = 1'b1;
        @(negedge clk);
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        for (int k = 0; k < 50 && mem_start; k++) @(negedge clk);
      end
    end
  end

  // Monitor: checks issue fields on each start edge and response data on each done pulse.
  initial begin
    exp_t        e;
    bit          prev_start = 1'b0, seen = 1'b0, prev_done = 1'b0;
    int          low_cnt = 0;
    logic [31:0] held_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (mem_start && !prev_start) begin
          if (sb.size() == 0) chk("unexpected_start", 1, 0);
          else begin
            e = sb[0];
            chk("issue", 1, {31'd0, e.issue});
            chk("num_bytes", {29'd0, mem_num_bytes}, {29'd0, e.nb});
            chk("addr", mem_addr, e.addr);
            chk("is_write", {31'd0, mem_is_write}, {31'd0, e.wr});
            if (e.wr) chk("wdata", mem_wdata, e.wdata);
          end
          if (seen) chk("start_gap>=2", {31'd0, low_cnt >= 2}, 1);
          seen      = 1'b1;
          held_addr = mem_addr;
          low_cnt   = 0;
        end else if (mem_start) begin
          chk("addr_held", mem_addr, held_addr);
        end
        if (!mem_start) low_cnt++;
        if (if_done || ls_done) begin
          chk("done_width", {31'd0, prev_done}, 0);
          if (sb.size() == 0) chk("unexpected_done", {30'd0, if_done, ls_done}, 0);
          else begin
            e = sb.pop_front();
            chk("done_owner", {30'd0, if_done, ls_done}, e.is_ls ? 32'd1 : 32'd2);
            if (e.is_ls) begin
              chk("ls_rdata", ls_rdata, e.rdata);
              chk("ls_err", {31'd0, ls_err}, {31'd0, e.err});
            end else begin
              chk("if_rdata", if_rdata, e.rdata);
            end
          end
        end
        prev_start = mem_start;
        prev_done  = if_done || ls_done;
      end
    end
  end

  task automatic wait_done(input bit is_ls, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      cyc++;
      got = is_ls ? ls_done : if_done;
    end
    if (!got) chk(is_ls ? "ls_done_timeout" : "if_done_timeout", 0, 1);
  endtask

  task automatic push_if(input logic [31:0] addr, input logic [31:0] rd, input int lat);
    sb.push_back('{is_ls: 1'b0, issue: 1'b1, nb: 3'd4, addr: addr, wr: 1'b0,
                   wdata: 32'd0, rdata: rd, err: 1'b0});
    mq.push_back('{lat: lat, data: rd});
  endtask

  task automatic push_ls(input bit wr, input logic [2:0] nb, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] raw, input logic [31:0] exp_rd);
    sb.push_back('{is_ls: 1'b1, issue: 1'b1, nb: nb, addr: addr, wr: wr,
                   wdata: wd, rdata: exp_rd, err: 1'b0});
    mq.push_back('{lat: 2, data: raw});
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rd);
    int cyc;
    push_if(addr, rd, 2);
    if_addr = addr;
    if_req  = 1'b1;
    wait_done(1'b0, cyc);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_ls(input bit wr, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] raw, input logic [2:0] nb,
                       input logic [31:0] exp_rd);
    int cyc;
    push_ls(wr, nb, addr, wd, raw, exp_rd);
    ls_write = wr; ls_size = size; ls_unsigned = uns; ls_addr = addr; ls_wdata = wd;
    ls_req = 1'b1;
    wait_done(1'b1, cyc);
    ls_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_start"}, {31'd0, mem_start}, 0);
    chk({tag, "_mem_nb"}, {29'd0, mem_num_bytes}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wr"}, {31'd0, mem_is_write}, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_ls_rdata"}, ls_rdata, 0);
    chk({tag, "_dones"}, {29'd0, if_done, ls_done, ls_err}, 0);
  endtask

  initial begin
    int cyc;
    bit started;
    rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_write = 1'b0; ls_unsigned = 1'b0;
    ls_size = 2'd0; if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_fetch(32'h0000_0100, 32'h1234_5678);
    do_ls(1'b0, 2'd0, 1'b0, 32'h0100_0010, 32'd0, 32'h80AB_CDEF, 3'd1, 32'hFFFF_FF80);
    do_ls(1'b0, 2'd0, 1'b1, 32'h0100_0011, 32'd0, 32'h80AB_CDEF, 3'd1, 32'h0000_0080);
    do_ls(1'b1, 2'd1, 1'b0, 32'h0100_0002, 32'hDEAD_BEEF, 32'h5555_5555, 3'd2, 32'h0000_0080);
    do_ls(1'b0, 2'd1, 1'b0, 32'h0100_0004, 32'd0, 32'h8001_1234, 3'd2, 32'hFFFF_8001);
    do_ls(1'b0, 2'd1, 1'b1, 32'h0100_0006, 32'd0, 32'hF00D_0000, 3'd2, 32'h0000_F00D);
    do_ls(1'b0, 2'd3, 1'b0, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 3'd4, 32'hCAFE_F00D);

    // Contention: load/store must win, fetch follows.
    push_ls(1'b0, 3'd1, 32'h0100_0020, 32'd0, 32'h7F00_0000, 32'h0000_007F);
    push_if(32'h0000_0104, 32'h0BAD_C0DE, 2);
    ls_write = 1'b0; ls_size = 2'd0; ls_unsigned = 1'b0; ls_addr = 32'h0100_0020;
    if_addr = 32'h0000_0104;
    ls_req = 1'b1; if_req = 1'b1;
    wait_done(1'b1, cyc);
    ls_req = 1'b0;
    wait_done(1'b0, cyc);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    sb.push_back('{is_ls: 1'b1, issue: 1'b0, nb: 3'd4, addr: 32'h0000_0002, wr: 1'b0,
                   wdata: 32'd0, rdata: 32'h0000_007F, err: 1'b1});
    ls_write = 1'b0; ls_size = 2'd2; ls_addr = 32'h0000_0002;
    ls_req = 1'b1;
    wait_done(1'b1, cyc);
    ls_req = 1'b0;
    chk("align_latency", cyc, 1);
    chk("align_no_start", {31'd0, mem_start}, 0);
    repeat (2) @(negedge clk);
`endif

    // Reset three cycles into BUSY: slow memory, no done expected.
    sb.push_back('{is_ls: 1'b0, issue: 1'b1, nb: 3'd4, addr: 32'h0000_0108, wr: 1'b0,
                   wdata: 32'd0, rdata: 32'd0, err: 1'b0});
    mq.push_back('{lat: 20, data: 32'hFFFF_FFFF});
    if_addr = 32'h0000_0108;
    if_req  = 1'b1;
    started = 1'b0;
    for (int k = 0; k < 20 && !started; k++) begin
      @(negedge clk);
      started = mem_start;
    end
    if (!started) chk("abort_start_timeout", 0, 1);
    repeat (3) @(negedge clk);
    rst_n  = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    rst_n = 1'b1;
    sb.delete();
    repeat (30) @(negedge clk);

    do_fetch(32'h0000_0000, 32'h0000_0013);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
